// File: rtl/axi_4_pkg.sv
// Shared AXI4 definitions: burst encodings, response codes and burst helpers.
package axi_4_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  // Address bit at which a 4 KB page boundary sits.
  localparam int BOUNDARY_4KB = 12;

  // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_legal(input logic [7:0] len);
    wrap_len_legal = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi4_strb_gen.sv
// Byte-lane strobe for one beat: lanes from the beat address up to the end of
// its size-aligned container within the bus. Shared with the write-data checker.
module axi4_strb_gen #(
  parameter int STROBE_WIDTH = 64,
  parameter int LANE_W       = 6
) (
  input  logic [LANE_W-1:0]       addr_lo,
  input  logic [2:0]              size,
  output logic [STROBE_WIDTH-1:0] strb
);

  // Mark every lane between the start byte and the last byte of the aligned container.
  always_comb begin
    int lo;
    int aligned;
    int hi;
    lo      = int'(addr_lo);
    aligned = (lo >> size) << size;
    hi      = aligned + (1 << size) - 1;
    strb    = '0;
    for (int i = 0; i < STROBE_WIDTH; i++) begin
      strb[i] = (i >= lo) && (i <= hi);
    end
  end

endmodule

// File: rtl/axi4_burst_addr_gen.sv
// AXI4 slave-side burst address generator: takes one AR/AW command and
// produces one registered beat descriptor per data transfer.
module axi4_burst_addr_gen
  import axi_4_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 32,
  parameter int DATA_BUS_WIDTH = 512,
  parameter int STROBE_WIDTH   = DATA_BUS_WIDTH / 8,
  parameter int SIZE_MAX       = $clog2(STROBE_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [2:0]              cmd_size,
  input  logic [1:0]              cmd_burst,
  output logic                    beat_valid,
  input  logic                    beat_ready,
  output logic [ID_WIDTH-1:0]     beat_id,
  output logic [ADDR_WIDTH-1:0]   beat_addr,
  output logic [STROBE_WIDTH-1:0] beat_strb,
  output logic [7:0]              beat_idx,
  output logic                    beat_last,
  output logic                    beat_err
);

  localparam int LANE_W = (SIZE_MAX > 0) ? SIZE_MAX : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  function automatic logic [ADDR_WIDTH-1:0] beat_bytes(input logic [2:0] size);
    beat_bytes = ADDR_WIDTH'(1) << size;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] align_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                       input logic [2:0]            size);
    align_addr = addr & ~(beat_bytes(size) - ADDR_WIDTH'(1));
  endfunction

  logic [0:0]              state_p0;
  logic                    vld_p0;
  logic [ID_WIDTH-1:0]     id_p0;
  logic [ADDR_WIDTH-1:0]   addr_p0;
  logic [ADDR_WIDTH-1:0]   wrap_lo_p0;
  logic [ADDR_WIDTH-1:0]   wrap_hi_p0;
  logic [STROBE_WIDTH-1:0] strb_p0;
  logic [7:0]              len_p0;
  logic [7:0]              idx_p0;
  logic [2:0]              size_p0;
  burst_t                  burst_p0;
  logic                    last_p0;
  logic                    err_p0;

  logic                    accept;
  logic                    beat_hs;
  logic [ADDR_WIDTH-1:0]   cmd_bytes;
  logic [ADDR_WIDTH-1:0]   cmd_total;
  logic [ADDR_WIDTH-1:0]   cmd_wrap_lo;
  logic [ADDR_WIDTH-1:0]   cmd_incr_end;
  logic                    cmd_err;
  logic [ADDR_WIDTH-1:0]   nxt_seq;
  logic [ADDR_WIDTH-1:0]   nxt_addr;
  logic [LANE_W-1:0]       strb_lo;
  logic [2:0]              strb_size;
  logic [STROBE_WIDTH-1:0] strb_nxt;

  assign beat_hs   = vld_p0 && beat_ready;
  assign cmd_ready = !rst && ((state_p0 == ST_IDLE) || (beat_hs && last_p0));
  assign accept    = cmd_valid && cmd_ready;

  // Command-side decode: wrap window and legality, evaluated once at accept.
  always_comb begin
    cmd_bytes    = beat_bytes(cmd_size);
    cmd_total    = cmd_bytes * (ADDR_WIDTH'(cmd_len) + ADDR_WIDTH'(1));
    // General modulo so the window stays well defined even for illegal wrap lengths.
    cmd_wrap_lo  = cmd_addr - (cmd_addr % cmd_total);
    cmd_incr_end = align_addr(cmd_addr, cmd_size) + cmd_total - ADDR_WIDTH'(1);
    cmd_err      = 1'b0;
    if (int'(cmd_size) > SIZE_MAX) cmd_err = 1'b1;
    unique case (burst_t'(cmd_burst))
      FIXED: if (cmd_len > 8'd15) cmd_err = 1'b1;
      INCR: begin
        if (cmd_incr_end[ADDR_WIDTH-1:BOUNDARY_4KB] != cmd_addr[ADDR_WIDTH-1:BOUNDARY_4KB])
          cmd_err = 1'b1;
      end
      WRAP: begin
        if (!wrap_len_legal(cmd_len)) cmd_err = 1'b1;
        if ((cmd_addr & (cmd_bytes - ADDR_WIDTH'(1))) != '0) cmd_err = 1'b1;
      end
      RSVD: cmd_err = 1'b1;
    endcase
  end

  // Beat-side address step; reserved bursts step like INCR so beats stay well formed.
  always_comb begin
    nxt_seq = addr_p0 + beat_bytes(size_p0);
    unique case (burst_p0)
      FIXED:   nxt_addr = addr_p0;
      WRAP:    nxt_addr = (nxt_seq == wrap_hi_p0) ? wrap_lo_p0 : nxt_seq;
      default: nxt_addr = align_addr(addr_p0, size_p0) + beat_bytes(size_p0);
    endcase
    strb_lo   = accept ? cmd_addr[LANE_W-1:0] : nxt_addr[LANE_W-1:0];
    strb_size = accept ? cmd_size : size_p0;
  end

  axi4_strb_gen #(
    .STROBE_WIDTH (STROBE_WIDTH),
    .LANE_W       (LANE_W)
  ) u_strb_gen (
    .addr_lo (strb_lo),
    .size    (strb_size),
    .strb    (strb_nxt)
  );

  // Burst FSM and beat descriptor registers; a new command reloads on the final handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0   <= ST_IDLE;
      vld_p0     <= 1'b0;
      id_p0      <= '0;
      addr_p0    <= '0;
      wrap_lo_p0 <= '0;
      wrap_hi_p0 <= '0;
      strb_p0    <= '0;
      len_p0     <= '0;
      idx_p0     <= '0;
      size_p0    <= '0;
      burst_p0   <= FIXED;
      last_p0    <= 1'b0;
      err_p0     <= 1'b0;
    end else if (accept) begin
      state_p0   <= ST_BURST;
      vld_p0     <= 1'b1;
      id_p0      <= cmd_id;
      addr_p0    <= cmd_addr;
      wrap_lo_p0 <= cmd_wrap_lo;
      wrap_hi_p0 <= cmd_wrap_lo + cmd_total;
      strb_p0    <= strb_nxt;
      len_p0     <= cmd_len;
      idx_p0     <= 8'd0;
      size_p0    <= cmd_size;
      burst_p0   <= burst_t'(cmd_burst);
      last_p0    <= (cmd_len == 8'd0);
      err_p0     <= cmd_err;
    end else if (beat_hs) begin
      if (last_p0) begin
        state_p0 <= ST_IDLE;
        vld_p0   <= 1'b0;
      end else begin
        addr_p0 <= nxt_addr;
        strb_p0 <= strb_nxt;
        idx_p0  <= idx_p0 + 8'd1;
        last_p0 <= ((idx_p0 + 8'd1) == len_p0);
      end
    end
  end

  assign beat_valid = vld_p0;
  assign beat_id    = id_p0;
  assign beat_addr  = addr_p0;
  assign beat_strb  = strb_p0;
  assign beat_idx   = idx_p0;
  assign beat_last  = last_p0;
  assign beat_err   = err_p0;

endmodule

// File: doc/axi4_burst_addr_gen.md
# axi4_burst_addr_gen

Parametrised AXI4 burst address generator for slave-side read and write paths. It accepts one AR/AW command (id, address, length, size, burst type) and emits one beat descriptor per data transfer: beat address, byte-lane strobe mask, beat index, last flag and protocol-error flag. FIXED, INCR and WRAP bursts are supported. Memory and peripheral slaves use it to drive their R/W data channels, replacing ad-hoc per-slave address counters.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width (matches XLEN).
- ID_WIDTH, 32, transaction id width.
- DATA_BUS_WIDTH, 512, data bus width in bits; power of two, 8..1024.
- STROBE_WIDTH, DATA_BUS_WIDTH/8, byte lanes (derived).
- SIZE_MAX, log2(STROBE_WIDTH), largest legal axsize (derived).

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_id  in  ID_WIDTH  awid/arid.
- cmd_addr  in  ADDR_WIDTH  axaddr.
- cmd_len  in  8  axlen (beats-1).
- cmd_size  in  3  axsize (bytes per beat = 2^size).
- cmd_burst  in  2  axburst.
- beat_valid  out  1  beat descriptor valid.
- beat_ready  in  1  consumer takes beat.
- beat_id  out  ID_WIDTH  id of current burst.
- beat_addr  out  ADDR_WIDTH  byte address of this beat.
- beat_strb  out  STROBE_WIDTH  active byte lanes for this beat.
- beat_idx  out  8  beat number, 0..len.
- beat_last  out  1  high on beat len.
- beat_err  out  1  burst is illegal; slave must respond SLVERR (2'b10).

## Operation
- FSM: IDLE, BURST. Reset state IDLE.
- cmd_ready = !rst && (IDLE || (beat_valid && beat_ready && beat_last)); combinational, enabling zero-bubble back-to-back bursts.
- Accept (cmd_valid && cmd_ready): latch all fields; BURST; beat_idx=0; beat_addr=cmd_addr; error check evaluated once and held for the whole burst.
- Each beat handshake (beat_valid && beat_ready): beat_idx+1; address advances per burst type. On the last-beat handshake: IDLE, or reload if a new command is accepted in the same cycle.
- Aligned address A = addr with low size bits cleared; B = 2^size.
- FIXED: every beat uses cmd_addr.
- INCR: beat 0 uses cmd_addr; beat n uses A0 + n*B (unaligned start only affects beat 0).
- WRAP: total T = B*(len+1); boundary W = floor(addr/T)*T. Next address is addr+B; if that equals W+T, it is W.
- beat_strb: lanes [addr mod STROBE_WIDTH .. (A mod STROBE_WIDTH)+B-1] set; all others clear.
- beat_err set if any of: cmd_burst==2'b11; cmd_size>SIZE_MAX; WRAP with len not in {1,3,7,15}; WRAP with unaligned addr; INCR crossing a 4 KB boundary (A0+(len+1)*B-1 has a different bit [ADDR_WIDTH-1:12] than cmd_addr); FIXED with len>15.
- Errored bursts still produce len+1 beats. Address and strobe are computed as normal, but beat_err=1 on every beat.
- Address arithmetic is modulo 2^ADDR_WIDTH.

## Timing
- Reset (rst high at edge): state IDLE; beat_valid, beat_id, beat_addr, beat_strb, beat_idx, beat_last and beat_err all 0. cmd_ready is 0 while rst is high.
- Reset mid-burst aborts the burst immediately; no further beats are produced.
- Latency: command accepted at edge k; beat 0 valid after edge k (same cycle as state BURST).
- Throughput: one beat per cycle while beat_ready is high.
- beat_valid is held with all beat fields stable until beat_ready; beat_ready low stalls without change.
- All beat outputs are registered; only cmd_ready is combinational.

## Structure
- Add to axi_4_pkg: burst_t enum (FIXED=2'b00, INCR=2'b01, WRAP=2'b10, RSVD=2'b11); resp constants OKAY=2'b00, SLVERR=2'b10; BOUNDARY_4KB=12.
- Sub-module axi4_strb_gen: combinational, takes addr low bits and size, produces beat_strb. It is reused by the write-data strobe checker.

## Test plan
- INCR, addr 0x1003, size 2, len 3 -> addrs 0x1003, 0x1004, 0x1008, 0x100C; strb beat0 = lane 3 only (0x8), beat1 = 0xF0; last on beat 3; err 0.
- WRAP, addr 0x1038, size 3, len 3 -> addrs 0x1038, 0x1020, 0x1028, 0x1030; strb beat0 = 0xFF<<56.
- FIXED, addr 0x2000, size 6, len 2 -> three beats at 0x2000, strb all-ones; then a second command held at cmd_valid is accepted on the last handshake, with no idle cycle.
- Errors: INCR 0x0FF0 size 4 len 1 (4 KB cross) -> 2 beats, err=1. burst 2'b11 -> err. WRAP len 2 -> err. size 7 -> err.
- Random beat_ready backpressure on a 16-beat INCR -> fields stable while stalled; idx 0..15 with no gaps.
- rst asserted at beat 2 of a 4-beat burst -> next cycle beat_valid=0 and all outputs 0; a new command is accepted cleanly after release.
